if_prefetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end with multiple outstanding requests. Replaces the one-request-at-a-time IF stage.

---
 rtl/if_prefetch_queue_if.sv | 26 ++
 rtl/if_prefetch_queue.sv | 206 ++++++++++++++++++++
 tb/tb_if_prefetch_queue.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/if_prefetch_queue_if.sv
// Instruction SRAM-like bus between the fetch front end and the memory side.
// The fetch unit is the master: it drives request/address and receives
// address-accept, data-return and read data.
interface if_prefetch_queue_if;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_req,
        output inst_sram_addr,
        input  inst_sram_addr_ok,
        input  inst_sram_data_ok,
        input  inst_sram_rdata
    );

    modport slave (
        input  inst_sram_req,
        input  inst_sram_addr,
        output inst_sram_addr_ok,
        output inst_sram_data_ok,
        output inst_sram_rdata
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end with multiple outstanding requests.
// Sequential PCs are issued on the inst bus, their tags are queued, and the
// in-order returned words are buffered with their PCs in a FIFO feeding decode.
// A redirect flushes everything and marks in-flight beats as stale.
module if_prefetch_queue #(
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'hbfc00000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    if_prefetch_queue_if.master        inst_bus,
    output logic                       fs_to_ds_valid,
    input  logic                       ds_allowin,
    output logic [31:0]                fs_pc,
    output logic [31:0]                fs_inst,
    output logic                       fs_adel
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;

    typedef enum logic [1:0] {ISSUE, HOLD, HALT} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } entry_t;

    state_e        state_q;
    logic [31:0]   fetch_pc_q;
    logic          pend_q;
    logic [31:0]   pend_pc_q;
    logic [CW-1:0] outst_q;
    logic [CW-1:0] discard_q;
    logic [31:0]   tag_mem_q [DEPTH];
    logic [AW-1:0] tag_wptr_q;
    logic [AW-1:0] tag_rptr_q;
    entry_t        fifo_q [DEPTH];
    logic [AW:0]   wptr_q;
    logic [AW:0]   rptr_q;

    logic [AW:0]   fifo_diff;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_empty;
    logic          fifo_full;
    logic          credit;
    logic          aligned;
    logic          req;
    logic          accept;
    logic          apply_redir;
    logic [31:0]   apply_pc;
    logic          push_adel;
    logic          data_keep;
    logic          push;
    logic          pop;
    entry_t        push_entry;
    entry_t        head;
    logic [CW-1:0] outst_next;

    assign fifo_diff  = wptr_q - rptr_q;
    assign fifo_cnt   = {1'b0, fifo_diff};
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign credit     = (outst_q < CW'(MAX_OUTST)) && ((outst_q + fifo_cnt) < CW'(DEPTH));
    assign aligned    = (fetch_pc_q[1:0] == 2'b00);

    // Request valid: gated by credit in ISSUE, held high in HOLD, silent in HALT or reset.
    always_comb begin
        req = 1'b0;
        if (!reset) begin
            case (state_q)
                ISSUE:   req = credit && !redirect_valid && aligned;
                HOLD:    req = 1'b1;
                default: req = 1'b0;
            endcase
        end
    end

    assign accept      = req && inst_bus.inst_sram_addr_ok;
    assign apply_redir = ((state_q != HOLD) && redirect_valid) ||
                         ((state_q == HOLD) && inst_bus.inst_sram_addr_ok && (redirect_valid || pend_q));
    assign apply_pc    = ((state_q == HOLD) && !redirect_valid) ? pend_pc_q : redirect_pc;
    assign push_adel   = (state_q == ISSUE) && !aligned && (outst_q == '0) && !fifo_full && !redirect_valid;
    assign data_keep   = inst_bus.inst_sram_data_ok && (discard_q == '0);
    assign push        = data_keep || push_adel;
    assign head        = fifo_q[rptr_q[AW-1:0]];
    assign pop         = fs_to_ds_valid && ds_allowin;
    assign outst_next  = outst_q + CW'(accept) - CW'(inst_bus.inst_sram_data_ok);

    // Entry written into the FIFO: an address-error marker or a returned word with its tag.
    always_comb begin
        push_entry = '{pc: tag_mem_q[tag_rptr_q], inst: inst_bus.inst_sram_rdata, adel: 1'b0};
        if (push_adel) begin
            push_entry = '{pc: fetch_pc_q, inst: 32'h0, adel: 1'b1};
        end
    end

    assign inst_bus.inst_sram_req  = req;
    assign inst_bus.inst_sram_addr = fetch_pc_q;
    assign fs_to_ds_valid          = !reset && !fifo_empty;
    assign fs_pc                   = head.pc;
    assign fs_inst                 = head.inst;
    assign fs_adel                 = head.adel;

    // Fetch FSM: advances the PC on accepted requests and parks redirects seen during HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ISSUE;
            fetch_pc_q <= RESET_PC;
            pend_q     <= 1'b0;
            pend_pc_q  <= 32'h0;
        end else if (apply_redir) begin
            state_q    <= ISSUE;
            fetch_pc_q <= apply_pc;
            pend_q     <= 1'b0;
        end else begin
            case (state_q)
                ISSUE: begin
                    if (accept) begin
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                    end else if (req) begin
                        state_q <= HOLD;
                    end else if (push_adel) begin
                        state_q <= HALT;
                    end
                end
                HOLD: begin
                    if (inst_bus.inst_sram_addr_ok) begin
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                        state_q    <= ISSUE;
                    end else if (redirect_valid) begin
                        pend_q    <= 1'b1;
                        pend_pc_q <= redirect_pc;
                    end
                end
                default: begin
                    state_q <= HALT;
                end
            endcase
        end
    end

    // Outstanding-request and stale-beat counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            outst_q   <= '0;
            discard_q <= '0;
        end else begin
            outst_q <= outst_next;
            if (apply_redir) begin
                discard_q <= outst_next;
            end else if (inst_bus.inst_sram_data_ok && (discard_q != '0)) begin
                discard_q <= discard_q - CW'(1);
            end
        end
    end

    // Tag queue pointers: one tag per live accepted request, popped on each kept beat.
    always_ff @(posedge clk) begin
        if (reset || apply_redir) begin
            tag_wptr_q <= '0;
            tag_rptr_q <= '0;
        end else begin
            if (accept) begin
                tag_wptr_q <= tag_wptr_q + AW'(1);
            end
            if (data_keep) begin
                tag_rptr_q <= tag_rptr_q + AW'(1);
            end
        end
    end

    // Tag storage: PC of each accepted request.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem_q[tag_wptr_q] <= fetch_pc_q;
        end
    end

    // Output FIFO pointers with wrap bit; cleared by reset and redirect.
    always_ff @(posedge clk) begin
        if (reset || apply_redir) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + (AW+1)'(1);
            end
        end
    end

    // Output FIFO storage.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q[AW-1:0]] <= push_entry;
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed self-checking bench for if_prefetch_queue (DEPTH=4, MAX_OUTST=2).
module tb_if_prefetch_queue;

    localparam logic [31:0] BASE = 32'hbfc00000;
    localparam logic [31:0] RPC  = 32'h80001000;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        allow;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expPc;
        logic [31:0] expInst;
        logic        expAdel;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        redirValid;
    logic [31:0] redirPc;
    logic        dsAllowin;
    logic        fsValid;
    logic [31:0] fsPc;
    logic [31:0] fsInst;
    logic        fsAdel;

    int checks;
    int errors;
    int accepts;

    vec_t vecTable[$];

    if_prefetch_queue_if bus ();

    if_prefetch_queue #(
        .DEPTH     (4),
        .MAX_OUTST (2),
        .RESET_PC  (BASE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirValid),
        .redirect_pc    (redirPc),
        .inst_bus       (bus),
        .fs_to_ds_valid (fsValid),
        .ds_allowin     (dsAllowin),
        .fs_pc          (fsPc),
        .fs_inst        (fsInst),
        .fs_adel        (fsAdel)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic rst, input logic redir, input logic [31:0] rpc,
                                input logic aok, input logic dok, input logic [31:0] rdata,
                                input logic allow, input logic eReq, input logic [31:0] eAddr,
                                input logic eValid, input logic [31:0] ePc, input logic [31:0] eInst,
                                input logic eAdel);
        vec_t v;
        v.rst = rst; v.redir = redir; v.rpc = rpc; v.aok = aok; v.dok = dok;
        v.rdata = rdata; v.allow = allow; v.expReq = eReq; v.expAddr = eAddr;
        v.expValid = eValid; v.expPc = ePc; v.expInst = eInst; v.expAdel = eAdel;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        reset                 = v.rst;
        redirValid            = v.redir;
        redirPc               = v.rpc;
        bus.inst_sram_addr_ok = v.aok;
        bus.inst_sram_data_ok = v.dok;
        bus.inst_sram_rdata   = v.rdata;
        dsAllowin             = v.allow;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive, sample on the falling edge, then let the rising edge commit.
    task automatic runVec(input string tag, input vec_t v);
        applyStimulus(v);
        @(negedge clk);
        if (bus.inst_sram_req && bus.inst_sram_addr_ok) accepts++;
        checkOutput({tag, " req"}, {31'b0, bus.inst_sram_req}, {31'b0, v.expReq});
        if (v.expReq) checkOutput({tag, " addr"}, bus.inst_sram_addr, v.expAddr);
        checkOutput({tag, " valid"}, {31'b0, fsValid}, {31'b0, v.expValid});
        if (v.expValid) begin
            checkOutput({tag, " pc"}, fsPc, v.expPc);
            checkOutput({tag, " inst"}, fsInst, v.expInst);
            checkOutput({tag, " adel"}, {31'b0, fsAdel}, {31'b0, v.expAdel});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input string tag);
        runVec(tag, mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        accepts = 0;
        reset = 1'b1; redirValid = 1'b0; redirPc = 32'h0; dsAllowin = 1'b1;
        bus.inst_sram_addr_ok = 1'b0; bus.inst_sram_data_ok = 1'b0; bus.inst_sram_rdata = 32'h0;

        // Streaming fetch with single-cycle data return, then a two-in-flight redirect.
        vecTable.push_back(mk(1, 0, 0,   0, 0, 0,            1, 0, 0,           0, 0,          0,            0));
        vecTable.push_back(mk(0, 0, 0,   1, 0, 0,            1, 1, BASE,        0, 0,          0,            0));
        vecTable.push_back(mk(0, 0, 0,   1, 1, 32'h11110000, 1, 1, BASE+4,      0, 0,          0,            0));
        vecTable.push_back(mk(0, 0, 0,   1, 1, 32'h11110004, 1, 1, BASE+8,      1, BASE,       32'h11110000, 0));
        vecTable.push_back(mk(0, 0, 0,   1, 1, 32'h11110008, 1, 1, BASE+12,     1, BASE+4,     32'h11110004, 0));
        vecTable.push_back(mk(0, 0, 0,   0, 1, 32'h1111000c, 1, 1, BASE+16,     1, BASE+8,     32'h11110008, 0));
        vecTable.push_back(mk(0, 0, 0,   0, 0, 0,            1, 1, BASE+16,     1, BASE+12,    32'h1111000c, 0));
        vecTable.push_back(mk(0, 0, 0,   1, 0, 0,            1, 1, BASE+16,     0, 0,          0,            0));
        vecTable.push_back(mk(0, 0, 0,   0, 1, 32'h11110010, 1, 1, BASE+20,     0, 0,          0,            0));
        vecTable.push_back(mk(0, 0, 0,   0, 0, 0,            1, 1, BASE+20,     1, BASE+16,    32'h11110010, 0));
        vecTable.push_back(mk(1, 0, 0,   0, 0, 0,            1, 0, 0,           0, 0,          0,            0));
        vecTable.push_back(mk(0, 0, 0,   1, 0, 0,            1, 1, BASE,        0, 0,          0,            0));
        vecTable.push_back(mk(0, 0, 0,   1, 0, 0,            1, 1, BASE+4,      0, 0,          0,            0));
        vecTable.push_back(mk(0, 1, RPC, 1, 0, 0,            1, 0, 0,           0, 0,          0,            0));
        vecTable.push_back(mk(0, 0, 0,   1, 1, 32'hdead0000, 1, 0, 0,           0, 0,          0,            0));
        vecTable.push_back(mk(0, 0, 0,   1, 1, 32'hdead0004, 1, 1, RPC,         0, 0,          0,            0));
        vecTable.push_back(mk(0, 0, 0,   0, 1, 32'h40000000, 1, 1, RPC+4,       0, 0,          0,            0));
        vecTable.push_back(mk(0, 0, 0,   0, 0, 0,            1, 1, RPC+4,       1, RPC,        32'h40000000, 0));

        for (int i = 0; i < vecTable.size(); i++) begin
            runVec($sformatf("tbl[%0d]", i), vecTable[i]);
        end

        // Decode stalled: FIFO fills after exactly four requests, then drains in order.
        doReset("t2 rst");
        accepts = 0;
        for (int i = 0; i < 8; i++) begin
            runVec($sformatf("t2 fill[%0d]", i),
                   mk(0, 0, 0, 1, (i >= 1 && i <= 4), 32'h20000000 + 32'(i - 1), 0,
                      (i < 4), BASE + 32'(4 * i), (i >= 2), BASE, 32'h20000000, 0));
        end
        checkOutput("t2 accepts", 32'(accepts), 32'd4);
        for (int j = 0; j < 5; j++) begin
            runVec($sformatf("t2 drain[%0d]", j),
                   mk(0, 0, 0, 0, 0, 0, 1, (j >= 1), BASE + 32'd16, (j < 4),
                      BASE + 32'(4 * j), 32'h20000000 + 32'(j), 0));
        end

        // Outstanding limit: only two handshakes until a data beat frees credit.
        doReset("t3 rst");
        accepts = 0;
        for (int i = 0; i < 6; i++) begin
            runVec($sformatf("t3 lim[%0d]", i),
                   mk(0, 0, 0, 1, (i == 5), 32'h30000000, 1, (i < 2), BASE + 32'(4 * i), 0, 0, 0, 0));
        end
        checkOutput("t3 accepts", 32'(accepts), 32'd2);
        runVec("t3 c6", mk(0, 0, 0, 1, 0, 0, 1, 1, BASE+8, 1, BASE, 32'h30000000, 0));
        runVec("t3 c7", mk(0, 0, 0, 1, 0, 0, 1, 0, 0,      0, 0,    0,            0));

        // Redirect during HOLD: address frozen, held beat dropped, fetch restarts at target.
        doReset("t5 rst");
        runVec("t5 c0", mk(0, 0, 0,   0, 0, 0,            1, 1, BASE,  0, 0,   0,            0));
        runVec("t5 c1", mk(0, 1, RPC, 0, 0, 0,            1, 1, BASE,  0, 0,   0,            0));
        runVec("t5 c2", mk(0, 0, 0,   0, 0, 0,            1, 1, BASE,  0, 0,   0,            0));
        runVec("t5 c3", mk(0, 0, 0,   0, 0, 0,            1, 1, BASE,  0, 0,   0,            0));
        runVec("t5 c4", mk(0, 0, 0,   1, 0, 0,            1, 1, BASE,  0, 0,   0,            0));
        runVec("t5 c5", mk(0, 0, 0,   1, 1, 32'hdead0000, 1, 1, RPC,   0, 0,   0,            0));
        runVec("t5 c6", mk(0, 0, 0,   0, 1, 32'h50000000, 1, 1, RPC+4, 0, 0,   0,            0));
        runVec("t5 c7", mk(0, 0, 0,   0, 0, 0,            1, 1, RPC+4, 1, RPC, 32'h50000000, 0));

        // Misaligned redirect: single address-error entry, fetch halts until the next redirect.
        doReset("t6 rst");
        runVec("t6 c0", mk(0, 1, 32'h80000002, 0, 0, 0, 1, 0, 0,            0, 0,            0, 0));
        runVec("t6 c1", mk(0, 0, 0,            0, 0, 0, 1, 0, 0,            0, 0,            0, 0));
        runVec("t6 c2", mk(0, 0, 0,            1, 0, 0, 0, 0, 0,            1, 32'h80000002, 0, 1));
        runVec("t6 c3", mk(0, 0, 0,            1, 0, 0, 0, 0, 0,            1, 32'h80000002, 0, 1));
        runVec("t6 c4", mk(0, 0, 0,            1, 0, 0, 1, 0, 0,            1, 32'h80000002, 0, 1));
        runVec("t6 c5", mk(0, 0, 0,            1, 0, 0, 1, 0, 0,            0, 0,            0, 0));
        runVec("t6 c6", mk(0, 1, 32'h80002000, 0, 0, 0, 1, 0, 0,            0, 0,            0, 0));
        runVec("t6 c7", mk(0, 0, 0,            0, 0, 0, 1, 1, 32'h80002000, 0, 0,            0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
